mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 192 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair; one bit per cycle.
// Build option: define MDU_DIVIDE_EN to include the restoring divider.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             hilo_read,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] opnd;
  logic             neg_pq;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             run_last;

  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_acc_next;
  logic [ACC_W-1:0] prod_res;

`ifdef MDU_DIVIDE_EN
  logic             is_div;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [ACC_W-1:0] div_acc_next;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;
`endif

  // Operand conditioning: signed ops iterate on magnitudes
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & operand_a[WIDTH-1];
  assign b_neg     = signed_op & operand_b[WIDTH-1];
  assign abs_a     = a_neg ? -operand_a : operand_a;
  assign abs_b     = b_neg ? -operand_b : operand_b;
  assign run_last  = (cnt == CNT_W'(WIDTH - 1));

  // Shift-add step: conditionally add multiplicand into the upper half, shift right
  assign mul_sum      = {1'b0, acc[ACC_W-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_acc_next = {mul_sum, acc[WIDTH-1:1]};
  assign prod_res     = neg_pq ? -acc : acc;

`ifdef MDU_DIVIDE_EN
  // Restoring step: upper half holds the partial remainder, lower half the dividend/quotient
  assign div_shift = acc[ACC_W-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  always_comb begin
    div_acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    if (!div_diff[WIDTH]) begin
      div_acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end
  assign quo_res = neg_pq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_res = neg_r ? -acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];
`endif

  assign stall = busy & (start | hilo_read | mthi | mtlo);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !flush) begin
`ifdef MDU_DIVIDE_EN
          state_next = RUN;
`else
          state_next = op[1] ? DONE : RUN;
`endif
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else if (run_last) begin
          state_next = FIXUP;
        end
      end
      FIXUP:   state_next = flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_pq   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MDU_DIVIDE_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
`endif
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start && !flush) begin
            cnt    <= '0;
            acc    <= {{WIDTH{1'b0}}, abs_a};
            opnd   <= abs_b;
            neg_pq <= a_neg ^ b_neg;
`ifdef MDU_DIVIDE_EN
            is_div   <= op[1];
            neg_r    <= a_neg;
            div_zero <= (operand_b == '0);
            raw_a    <= operand_a;
`endif
          end
          if (mthi) hi <= operand_a;
          if (mtlo) lo <= operand_a;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
`ifdef MDU_DIVIDE_EN
          acc <= is_div ? div_acc_next : mul_acc_next;
`else
          acc <= mul_acc_next;
`endif
        end
        FIXUP: begin
          if (!flush) begin
`ifdef MDU_DIVIDE_EN
            if (is_div) begin
              // Divide by zero reports the original dividend and an all-ones quotient
              hi <= div_zero ? raw_a : rem_res;
              lo <= div_zero ? {WIDTH{1'b1}} : quo_res;
            end else begin
              hi <= prod_res[ACC_W-1:WIDTH];
              lo <= prod_res[WIDTH-1:0];
            end
`else
            hi <= prod_res[ACC_W-1:WIDTH];
            lo <= prod_res[WIDTH-1:0];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a 32-bit instance for the main sequence
// and an 8-bit instance for narrow-width and mid-run reset behaviour.
module tb_mult_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, flush, hilo_read, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  logic        r8, s8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, stall8;
  logic [7:0]  hi8, lo8;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int seen;

  mult_div_unit #(.WIDTH(32)) u32 (
    .clock(clk), .reset(reset), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .flush(flush), .hilo_read(hilo_read),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .stall(stall),
    .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) u8 (
    .clock(clk), .reset(r8), .start(s8), .op(op8),
    .operand_a(a8), .operand_b(b8), .flush(1'b0), .hilo_read(1'b0),
    .mthi(1'b0), .mtlo(1'b0), .busy(busy8), .done(done8), .stall(stall8),
    .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit unit; lat counts edges from the accepting edge to done
  task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1 chk("stall_at_issue", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; hilo_read = 1'b0;
    mthi = 1'b0; mtlo = 1'b0; op = 2'b00; a = '0; b = '0;
    r8 = 1'b1; s8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0; r8 = 1'b0;

    // MULT -2 * 3
    issue32(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_lat", 32'(lat), 32'd34);
    chk("mult_busy_in_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("mult_done_cleared", 32'(done), 32'd0);
    chk("mult_busy_cleared", 32'(busy), 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // MULTU max * max
    issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_lat", 32'(lat), 32'd34);
    @(posedge clk); #1;
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2, DIVU 7 / 0, DIV most-negative / -1
    issue32(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
`ifdef MDU_DIVIDE_EN
    chk("div_lat", 32'(lat), 32'd34);
    @(posedge clk); #1;
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
`else
    chk("div_lat", 32'(lat), 32'd1);
    chk("div_busy_in_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("div_hi", hi, 32'hFFFF_FFFE);
    chk("div_lo", lo, 32'h0000_0001);
`endif
    issue32(2'b11, 32'h0000_0007, 32'h0000_0000);
    @(posedge clk); #1;
`ifdef MDU_DIVIDE_EN
    chk("divz_hi", hi, 32'h0000_0007);
    chk("divz_lo", lo, 32'hFFFF_FFFF);
`else
    chk("divz_hi", hi, 32'hFFFF_FFFE);
    chk("divz_lo", lo, 32'h0000_0001);
`endif
    issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clk); #1;
`ifdef MDU_DIVIDE_EN
    chk("divovf_hi", hi, 32'h0000_0000);
    chk("divovf_lo", lo, 32'h8000_0000);
`else
    chk("divovf_hi", hi, 32'hFFFF_FFFE);
    chk("divovf_lo", lo, 32'h0000_0001);
`endif

    // MTHI / MTLO in IDLE
    @(negedge clk);
    a = 32'h1234_5678; mthi = 1'b1;
    @(negedge clk);
    a = 32'h9ABC_DEF0; mthi = 1'b0; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mthi", hi, 32'h1234_5678);
    chk("mtlo", lo, 32'h9ABC_DEF0);

    // flush and start together in IDLE: nothing starts
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("flush_start_lo", lo, 32'h9ABC_DEF0);

    // MULTU 5 * 6 with an ignored start at cycle 5 and hilo_read from cycle 10
    @(negedge clk);
    op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'd9; b = 32'd9;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      start = (lat == 5);
      hilo_read = (lat >= 10);
      #1;
      if (lat == 5) chk("stall_start_busy", 32'(stall), 32'd1);
      if (lat == 10) chk("stall_hilo_read", 32'(stall), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("stall_op_lat", 32'(lat), 32'd34);
    chk("stall_in_done", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("stall_after_done", 32'(stall), 32'd0);
    chk("stall_op_lo", lo, 32'd30);
    chk("stall_op_hi", hi, 32'd0);
    hilo_read = 1'b0;

    // Flush at RUN cycle 5: no done, HI/LO retained
    @(negedge clk);
`ifdef MDU_DIVIDE_EN
    op = 2'b11;
`else
    op = 2'b01;
`endif
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'd30);

    issue32(2'b00, 32'd3, 32'd4);
    @(posedge clk); #1;
    chk("mult34_hi", hi, 32'd0);
    chk("mult34_lo", lo, 32'd12);

    // 8-bit instance: signed most-negative squared, then reset mid-run
    issue8(2'b00, 8'h80, 8'h80);
    chk("w8_mult_lat", 32'(lat), 32'd10);
    @(posedge clk); #1;
    chk("w8_mult_hi", 32'(hi8), 32'h40);
    chk("w8_mult_lo", 32'(lo8), 32'h00);

    @(negedge clk);
    op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
    @(posedge clk); #1;
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    r8 = 1'b1;
    @(posedge clk); #1;
    chk("w8_rst_busy", 32'(busy8), 32'd0);
    chk("w8_rst_done", 32'(done8), 32'd0);
    chk("w8_rst_stall", 32'(stall8), 32'd0);
    chk("w8_rst_hi", 32'(hi8), 32'h00);
    chk("w8_rst_lo", 32'(lo8), 32'h00);
    @(negedge clk);
    r8 = 1'b0;

    issue8(2'b01, 8'hFF, 8'hFF);
    chk("w8_multu_lat", 32'(lat), 32'd10);
    @(posedge clk); #1;
    chk("w8_multu_hi", 32'(hi8), 32'hFE);
    chk("w8_multu_lo", 32'(lo8), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
